// File: rtl/fft32_mdc_ctrl.sv
// Sequencer for a 32-point radix-2 MDC FFT: input handshake with zero padding, a token pipe that
// tracks every fed pair through the stages, and per-stage twiddle/commutator/output indices.
module fft32_mdc_ctrl #(
  parameter int BF_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       zero_pad,
  output logic       feed,
  output logic [3:0] rom_s1_counter,
  output logic [2:0] rom_s2_counter,
  output logic [1:0] rom_s3_counter,
  output logic       rom_s4_counter,
  output logic [3:0] sw,
  output logic       out_valid,
  output logic       out_last,
  output logic       frame_err
);

  // Stage input taps and output tap of the token pipe.
  localparam int L2   = BF_LAT + 8;
  localparam int L3   = L2 + BF_LAT + 4;
  localparam int L4   = L3 + BF_LAT + 2;
  localparam int LOUT = 5 * BF_LAT + 15;

  typedef enum logic [1:0] {IDLE, RUN, PAD} state_e;

  state_e            state_q;
  logic [3:0]        fc_q;
  logic [LOUT-1:0]   tok_q;
  logic [3:0]        c_q [4];
  logic [3:0]        k_q [4];
  logic [3:0]        oidx_q;

  logic              run_gap;
  logic [3:0]        v;
  logic [3:0]        cv;

  // The handshake outputs react to in_valid in the same cycle so a gap is padded without delay.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
    run_gap  = (state_q == RUN) && !in_valid;
    in_ready = !rst && ((state_q == IDLE) || ((state_q == RUN) && in_valid));
    zero_pad = !rst && ((state_q == PAD) || run_gap);
    frame_err = !rst && run_gap;
    feed     = (in_valid && in_ready) || zero_pad;

    v  = {tok_q[L4-1], tok_q[L3-1], tok_q[L2-1], feed};
    cv = {tok_q[L4+BF_LAT-1], tok_q[L3+BF_LAT-1], tok_q[L2+BF_LAT-1], tok_q[BF_LAT-1]};
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      fc_q    <= '0;
      tok_q   <= '0;
      oidx_q  <= '0;
      for (int s = 0; s < 4; s++) begin
        c_q[s] <= '0;
        k_q[s] <= '0;
      end
    end else begin
      tok_q <= {tok_q[LOUT-2:0], feed};
      if (tok_q[LOUT-1]) oidx_q <= oidx_q + 4'd1;
      for (int s = 0; s < 4; s++) begin
        if (v[s])  c_q[s] <= c_q[s] + 4'd1;
        if (cv[s]) k_q[s] <= k_q[s] + 4'd1;
      end
      if (feed) fc_q <= fc_q + 4'd1;

      unique case (state_q)
        IDLE: if (feed) state_q <= RUN;
        RUN: begin
          // A gap on the last pair still completes the frame with that single pad.
          if (fc_q == 4'd15)  state_q <= IDLE;
          else if (!in_valid) state_q <= PAD;
        end
        PAD: if (fc_q == 4'd15) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Everything is forced low while reset is held, including the registered indices.
  assign rom_s1_counter = rst ? '0 : c_q[0];
  assign rom_s2_counter = rst ? '0 : c_q[1][2:0];
  assign rom_s3_counter = rst ? '0 : c_q[2][1:0];
  assign rom_s4_counter = rst ? 1'b0 : c_q[3][0];
  assign sw             = rst ? '0 : {k_q[3][0], k_q[2][1], k_q[1][2], k_q[0][3]};
  assign out_valid      = !rst && tok_q[LOUT-1];
  assign out_last       = out_valid && (oidx_q == 4'd15);

endmodule

// File: tb/tb_fft32_mdc_ctrl.sv
// Bench for fft32_mdc_ctrl: a frame-level model checked every cycle against BF_LAT=1 and
// BF_LAT=2 instances, plus directed scenarios pinned with literal expectations.
module tb_fft32_mdc_ctrl;
  localparam int MAXC = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;

  logic       a_ready, a_zp, a_feed, a_r4, a_ov, a_last, a_err;
  logic [3:0] a_r1, a_sw;
  logic [2:0] a_r2;
  logic [1:0] a_r3;
  logic       b_ready, b_zp, b_feed, b_r4, b_ov, b_last, b_err;
  logic [3:0] b_r1, b_sw;
  logic [2:0] b_r2;
  logic [1:0] b_r3;

  fft32_mdc_ctrl #(.BF_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready), .zero_pad(a_zp),
    .feed(a_feed), .rom_s1_counter(a_r1), .rom_s2_counter(a_r2), .rom_s3_counter(a_r3),
    .rom_s4_counter(a_r4), .sw(a_sw), .out_valid(a_ov), .out_last(a_last), .frame_err(a_err)
  );

  fft32_mdc_ctrl #(.BF_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready), .zero_pad(b_zp),
    .feed(b_feed), .rom_s1_counter(b_r1), .rom_s2_counter(b_r2), .rom_s3_counter(b_r3),
    .rom_s4_counter(b_r4), .sw(b_sw), .out_valid(b_ov), .out_last(b_last), .frame_err(b_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int r0 = 0;
  bit prev_rst = 1'b1;

  // Frame-level model of the input side.
  int pos = 0;
  bit padding = 1'b0;
  int e_ready, e_zp, e_feed, e_err;

  int cum [MAXC+1];
  bit fed [MAXC];

  int lg_ready [MAXC];
  int lg_zp [MAXC];
  int lg_err [MAXC];
  int lg_rom1 [MAXC];
  int lg_rom2 [MAXC];
  int lg_rom4 [MAXC];
  int lg_sw0 [MAXC];
  int lg_ov [MAXC];
  int lg_last [MAXC];
  int lg_ov_b [MAXC];
  int lg_rom2_b [MAXC];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Number of pairs fed in cycles [r0, m].
  function automatic int cnt(input int m);
    if (m < r0) return 0;
    return cum[m+1] - cum[r0];
  endfunction

  // Input tap of stage s (1..4), or the output tap minus BF_LAT for s = 5.
  function automatic int tap(input int bf, input int s);
    int l = 0;
    for (int i = 1; i < s; i++) l += bf + (16 >> i);
    return l;
  endfunction

  task automatic cmp_dut(input string tag, input int bf, input int ready, input int zp,
                         input int fd, input int err, input int r1, input int r2, input int r3,
                         input int r4, input int swv, input int ov, input int last);
    int lout, n, x_r1, x_r2, x_r3, x_r4, x_sw, x_ov, x_last;
    lout = tap(bf, 5) + bf;
    n = cyc - lout;
    x_r1 = 0; x_r2 = 0; x_r3 = 0; x_r4 = 0; x_sw = 0; x_ov = 0; x_last = 0;
    if (!rst) begin
      x_r1 = cnt(cyc - 1 - tap(bf, 1)) % 16;
      x_r2 = cnt(cyc - 1 - tap(bf, 2)) % 8;
      x_r3 = cnt(cyc - 1 - tap(bf, 3)) % 4;
      x_r4 = cnt(cyc - 1 - tap(bf, 4)) % 2;
      for (int s = 1; s <= 4; s++)
        x_sw += ((cnt(cyc - 1 - tap(bf, s) - bf) >> (4 - s)) & 1) << (s - 1);
      x_ov = (n >= r0) ? int'(fed[n]) : 0;
      x_last = (x_ov != 0 && cnt(n - 1) % 16 == 15) ? 1 : 0;
    end
    check({tag, ".in_ready"}, ready, e_ready);
    check({tag, ".zero_pad"}, zp, e_zp);
    check({tag, ".feed"}, fd, e_feed);
    check({tag, ".frame_err"}, err, e_err);
    check({tag, ".rom_s1"}, r1, x_r1);
    check({tag, ".rom_s2"}, r2, x_r2);
    check({tag, ".rom_s3"}, r3, x_r3);
    check({tag, ".rom_s4"}, r4, x_r4);
    check({tag, ".sw"}, swv, x_sw);
    check({tag, ".out_valid"}, ov, x_ov);
    check({tag, ".out_last"}, last, x_last);
  endtask

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      e_err = 0;
      e_zp = 0;
      if (rst) begin
        pos = 0; padding = 1'b0; e_ready = 0; e_feed = 0;
      end else begin
        if (prev_rst) r0 = cyc;
        if (padding) begin
          e_ready = 0; e_zp = 1; e_feed = 1;
        end else if (pos == 0) begin
          e_ready = 1; e_feed = int'(in_valid);
        end else if (in_valid) begin
          e_ready = 1; e_feed = 1;
        end else begin
          e_ready = 0; e_zp = 1; e_feed = 1; e_err = 1; padding = 1'b1;
        end
        if (e_feed != 0) begin
          pos = (pos + 1) % 16;
          if (pos == 0) padding = 1'b0;
        end
      end
      fed[cyc] = (e_feed != 0);
      cum[cyc+1] = cum[cyc] + e_feed;
      cmp_dut("bf1", 1, a_ready, a_zp, a_feed, a_err, a_r1, a_r2, a_r3, a_r4, a_sw, a_ov, a_last);
      cmp_dut("bf2", 2, b_ready, b_zp, b_feed, b_err, b_r1, b_r2, b_r3, b_r4, b_sw, b_ov, b_last);
      lg_ready[cyc] = a_ready; lg_zp[cyc] = a_zp; lg_err[cyc] = a_err;
      lg_rom1[cyc] = a_r1; lg_rom2[cyc] = a_r2; lg_rom4[cyc] = a_r4; lg_sw0[cyc] = a_sw[0];
      lg_ov[cyc] = a_ov; lg_last[cyc] = a_last; lg_ov_b[cyc] = b_ov; lg_rom2_b[cyc] = b_r2;
      prev_rst = rst;
      cyc++;
    end
  end

  task automatic step(input logic v, input logic r);
    @(posedge clk);
    #1;
    in_valid = v;
    rst = r;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  int t, c, c2;

  initial begin
    // Reset and the first ready cycle.
    repeat (3) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    t = cyc;
    idle(3);
    check("rst_ready_low", lg_ready[t-1], 0);
    check("ready_after_rst", lg_ready[t], 1);

    // One clean frame.
    step(1'b1, 1'b0); t = cyc;
    repeat (15) step(1'b1, 1'b0);
    idle(45);
    for (int k = 0; k < 16; k++) check("s1_rom1_step", lg_rom1[t+k], k);
    c = 0;
    for (int k = 0; k < 16; k++) c += lg_ready[t+k];
    check("s1_ready_held", c, 16);
    check("s1_ov_pre", lg_ov[t+19], 0);
    check("s1_ov_first", lg_ov[t+20], 1);
    check("s1_ov_end", lg_ov[t+35], 1);
    check("s1_ov_post", lg_ov[t+36], 0);
    check("s1_last", lg_last[t+35], 1);
    check("s1_last_early", lg_last[t+34], 0);
    check("s1_rom2_tap9", lg_rom2[t+10], 1);
    check("s5_bf2_ov_pre", lg_ov_b[t+24], 0);
    check("s5_bf2_ov_first", lg_ov_b[t+25], 1);
    check("s5_bf2_rom2_pre", lg_rom2_b[t+10], 0);
    check("s5_bf2_rom2_tap10", lg_rom2_b[t+11], 1);

    // Two back-to-back frames.
    step(1'b1, 1'b0); t = cyc;
    repeat (31) step(1'b1, 1'b0);
    idle(60);
    check("s2_rom4_a", lg_rom4[t+17], 0);
    check("s2_rom4_b", lg_rom4[t+18], 1);
    check("s2_rom4_c", lg_rom4[t+19], 0);
    check("s2_sw0_idx7", lg_sw0[t+8], 0);
    check("s2_sw0_idx8", lg_sw0[t+9], 1);
    check("s2_sw0_idx15", lg_sw0[t+16], 1);
    check("s2_sw0_f2_idx0", lg_sw0[t+17], 0);
    check("s2_sw0_f2_idx8", lg_sw0[t+25], 1);
    c = 0; c2 = 0;
    for (int k = 20; k <= 51; k++) begin c += lg_ov[t+k]; c2 += lg_last[t+k]; end
    check("s2_ov_run", c, 32);
    check("s2_last_count", c2, 2);
    check("s2_last_a", lg_last[t+35], 1);
    check("s2_last_b", lg_last[t+51], 1);
    check("s2_ov_post", lg_ov[t+52], 0);

    // Aborted frame padded with zeros.
    step(1'b1, 1'b0); t = cyc;
    repeat (4) step(1'b1, 1'b0);
    idle(45);
    check("s3_err_pre", lg_err[t+4], 0);
    check("s3_err", lg_err[t+5], 1);
    check("s3_err_post", lg_err[t+6], 0);
    c = 0; c2 = 0;
    for (int k = 5; k <= 15; k++) begin c += lg_ready[t+k]; c2 += lg_zp[t+k]; end
    check("s3_ready_low", c, 0);
    check("s3_zp_high", c2, 11);
    check("s3_zp_end", lg_zp[t+16], 0);
    check("s3_ready_back", lg_ready[t+16], 1);
    c = 0;
    for (int k = 20; k <= 35; k++) c += lg_ov[t+k];
    check("s3_ov_span", c, 16);
    check("s3_ov_post", lg_ov[t+36], 0);
    check("s3_last", lg_last[t+35], 1);

    // Reset in the middle of a frame, then a clean frame.
    step(1'b1, 1'b0); t = cyc;
    repeat (6) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    idle(45);
    c = 0;
    for (int k = 0; k <= 52; k++) c += lg_ov[t+k];
    check("s4_no_ov", c, 0);
    check("s4_rom1_pre", lg_rom1[t+6], 6);
    check("s4_rom1_rst", lg_rom1[t+8], 0);
    check("s4_ready_rst", lg_ready[t+8], 0);
    check("s4_ready_back", lg_ready[t+9], 1);
    step(1'b1, 1'b0); t = cyc;
    repeat (15) step(1'b1, 1'b0);
    idle(45);
    check("s4b_rom1", lg_rom1[t+15], 15);
    check("s4b_ov_pre", lg_ov[t+19], 0);
    check("s4b_ov_first", lg_ov[t+20], 1);
    check("s4b_last", lg_last[t+35], 1);

    // Padded frame with in_valid held high: next frame starts without a gap.
    step(1'b1, 1'b0); t = cyc;
    repeat (2) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (28) step(1'b1, 1'b0);
    idle(45);
    check("s6_err", lg_err[t+3], 1);
    c = 0;
    for (int k = 4; k <= 40; k++) c += lg_err[t+k];
    check("s6_err_quiet", c, 0);
    check("s6_ready_pad", lg_ready[t+15], 0);
    check("s6_ready_next", lg_ready[t+16], 1);
    check("s6_zp_next", lg_zp[t+16], 0);
    c = 0;
    for (int k = 20; k <= 51; k++) c += lg_ov[t+k];
    check("s6_ov_run", c, 32);
    check("s6_last_a", lg_last[t+35], 1);
    check("s6_last_b", lg_last[t+51], 1);

    // Gap on the very last pair of a frame.
    step(1'b1, 1'b0); t = cyc;
    repeat (14) step(1'b1, 1'b0);
    idle(40);
    check("s7_err", lg_err[t+15], 1);
    check("s7_zp", lg_zp[t+15], 1);
    check("s7_zp_end", lg_zp[t+16], 0);
    check("s7_ready_back", lg_ready[t+16], 1);
    check("s7_last", lg_last[t+35], 1);
    check("s7_ov_post", lg_ov[t+36], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
